// File: rtl/intr_controller_if.sv
// intr_controller_if: CPU-side bundle of the interrupt controller.
// Ports (signals):
//   irq_in    - raw asynchronous interrupt levels, NIRQ bits
//   int_req   - interrupt request to the CPU
//   int_id    - id of the requested line, valid while int_req=1
//   int_ack   - one-cycle pulse, CPU accepts the request
//   eoi       - one-cycle pulse, CPU finished the current handler
//   reg_addr  - register select
//   reg_wr    - register write strobe
//   reg_wdata - register write data
//   reg_rdata - register read data, combinational from reg_addr
// Modports: master drives the CPU side, slave is the controller.
interface intr_controller_if #(
    parameter int NIRQ = 6,
    parameter int IDW  = 3
);
    logic [NIRQ-1:0] irq_in;
    logic            int_req;
    logic [IDW-1:0]  int_id;
    logic            int_ack;
    logic            eoi;
    logic [1:0]      reg_addr;
    logic            reg_wr;
    logic [NIRQ-1:0] reg_wdata;
    logic [7:0]      reg_rdata;

    modport master (
        output irq_in, int_ack, eoi, reg_addr, reg_wr, reg_wdata,
        input  int_req, int_id, reg_rdata
    );

    modport slave (
        input  irq_in, int_ack, eoi, reg_addr, reg_wr, reg_wdata,
        output int_req, int_id, reg_rdata
    );
endinterface

// File: rtl/intr_controller.sv
// intr_controller: prioritised, maskable, nesting interrupt controller.
// Ports:
//   clock - system clock, rising edge
//   reset - synchronous, active-high
//   bus   - intr_controller_if.slave (irq lines, request/ack/eoi, register port)
module intr_controller #(
    parameter int NIRQ = 6,
    parameter int IDW  = 3
) (
    input  logic             clock,
    input  logic             reset,
    intr_controller_if.slave bus
);
    typedef enum logic {IDLE, REQ} state_e;

    state_e          state_q, state_d;
    logic [NIRQ-1:0] s1_q, s2_q, s3_q;
    logic [NIRQ-1:0] pend_q, pend_d, ier_q, ier_d, isr_q, isr_d;
    logic [IDW-1:0]  id_q, id_d, win;
    logic [NIRQ-1:0] ev, elig, id_oh, clr;
    logic            ack_fire;

    assign ev       = s2_q & ~s3_q;
    assign id_oh    = NIRQ'(1) << id_q;
    assign ack_fire = state_q == REQ && bus.int_ack;
    // isr | -isr masks every line at or below the priority of the highest in-service one
    assign elig     = pend_q & ier_q & ~(isr_q | (~isr_q + NIRQ'(1)));

    always_comb begin
        win = '0;
        for (int i = NIRQ - 1; i >= 0; i--)
            if (elig[i]) win = IDW'(i);
    end

    always_comb begin
        state_d = state_q;
        id_d    = id_q;
        if (state_q == IDLE) begin
            if (|elig) begin
                state_d = REQ;
                id_d    = win;
            end
        end else if (bus.int_ack || (pend_q & ier_q & id_oh) == '0) begin
            state_d = IDLE;
        end
    end

    // Set beats clear; eoi drops the lowest set ISR bit before the ack bit is added
    assign clr    = (ack_fire ? id_oh : '0) | (bus.reg_wr && bus.reg_addr == 2'd1 ? bus.reg_wdata : '0);
    assign pend_d = (pend_q & ~clr) | ev;
    assign ier_d  = bus.reg_wr && bus.reg_addr == 2'd0 ? bus.reg_wdata : ier_q;
    assign isr_d  = (bus.eoi ? isr_q & (isr_q - NIRQ'(1)) : isr_q) | (ack_fire ? id_oh : '0);

    assign bus.int_req   = state_q == REQ;
    assign bus.int_id    = id_q;
    assign bus.reg_rdata = bus.reg_addr == 2'd0 ? 8'(ier_q)  :
                           bus.reg_addr == 2'd1 ? 8'(pend_q) :
                           bus.reg_addr == 2'd2 ? 8'(isr_q)  :
                           {state_q == REQ, 7'(id_q)};

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            id_q    <= '0;
            s1_q    <= '0;
            s2_q    <= '0;
            s3_q    <= '0;
            pend_q  <= '0;
            ier_q   <= '0;
            isr_q   <= '0;
        end else begin
            state_q <= state_d;
            id_q    <= id_d;
            s1_q    <= bus.irq_in;
            s2_q    <= s1_q;
            s3_q    <= s2_q;
            pend_q  <= pend_d;
            ier_q   <= ier_d;
            isr_q   <= isr_d;
        end
    end
endmodule

// File: doc/intr_controller.md
# intr_controller

Prioritised, maskable, nesting interrupt controller for the Minisys-1A CPU. It takes the six raw interrupt lines (keyboard on line 0, buttons S1–S5 on lines 1–5) and synchronises and edge-detects them. Events are latched as pending, gated by a software enable register, and the highest-priority eligible line is presented to the CPU with a request/acknowledge/end-of-interrupt handshake. A small register port lets the CPU configure and inspect the controller.

## Interface
Parameters:
- `NIRQ`, 6, number of interrupt lines; line 0 has the highest priority.
- `IDW`, 3, width of the interrupt id (≥ clog2(NIRQ)).

Ports:
- `clock` in 1: single system clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `irq_in` in NIRQ: raw asynchronous interrupt levels.
- `int_req` out 1: interrupt request to the CPU.
- `int_id` out IDW: id of the requested line; valid while `int_req`=1.
- `int_ack` in 1: one-cycle pulse; CPU accepts the request.
- `eoi` in 1: one-cycle pulse; CPU finished the current handler (eret).
- `reg_addr` in 2: register select.
- `reg_wr` in 1: write strobe.
- `reg_wdata` in NIRQ: write data.
- `reg_rdata` out 8: read data, combinational from `reg_addr`.

## Operation
- **Synchroniser and edge detection:** each `irq_in` bit passes through a 2-flop synchroniser plus a history flop. An event is a synchronised rising edge (s2 & ~s3). A level held high produces exactly one event.
- **PEND[NIRQ]:** a bit is set by an event on its line. It is cleared when that line is acknowledged, or by a software write-1-to-clear.
- **IER[NIRQ]:** per-line enable, read/write. Disabled lines still latch into PEND but never request.
- **ISR[NIRQ]:** in-service bits. A bit is set on `int_ack` for the `int_id` line. `eoi` clears the lowest-numbered (highest-priority) set ISR bit.
- **Eligibility:** candidate = PEND & IER. The winner is the lowest-index candidate. It is eligible only if its index is below the lowest set ISR bit; an empty ISR means any candidate is eligible. This allows nesting with preemption by strictly higher priority only.
- **FSM states:**
  - IDLE: `int_req`=0. Moves to REQ when an eligible winner exists; the winner index is latched into `int_id`.
  - REQ: `int_req`=1. `int_id` is held stable even if a higher-priority event arrives. On `int_ack`, move to IDLE, clear PEND[`int_id`], set ISR[`int_id`].
  - If software clears the latched PEND bit or its IER bit while in REQ, the request is withdrawn: move to IDLE and re-arbitrate next cycle.
- **Register map:**
  - addr 0: IER (R/W).
  - addr 1: PEND (R, W1C).
  - addr 2: ISR (R only; writes ignored).
  - addr 3: status, read-only, {`int_req`, 4'b0, `int_id`}.
  - Unused upper bits of `reg_rdata` read 0.
- **Simultaneous events:**
  - Event and clear (ack or W1C) on the same bit in the same cycle: set wins, and the bit stays pending.
  - `eoi` and `int_ack` in the same cycle: `eoi` clears the highest-priority bit of the old ISR, then the ack bit is set.
  - `eoi` with ISR empty: no effect.
  - `int_ack` outside REQ: ignored.
  - A register write and arbitration in the same cycle: arbitration uses the pre-write values; the new values take effect from the next cycle.

## Timing
- **Reset values:** all synchroniser flops, PEND, IER and ISR are 0. The FSM is in IDLE, `int_req`=0, `int_id`=0, and `reg_rdata` reflects the zeroed registers.
- **Event latency:** with `irq_in` rising before clock edge k, the PEND bit is set after edge k+2 and `int_req` is high after edge k+3, provided the line is enabled and eligible.
- **Acknowledge:** `int_req` falls on the edge that samples `int_ack`. The earliest new `int_req` is one cycle after the state returns to IDLE.
- **EOI:** an ISR clear on `eoi` can make a blocked pending line eligible. That request rises one cycle after the ISR update.
- **Reset mid-operation:** `reset` asserted in any state returns to IDLE in the same edge and drops all pending and in-service state. Events in flight in the synchroniser are discarded.

## Test plan
- **Basic request:** reset; write IER=6'h3F; pulse `irq_in[3]` for 5 cycles -> `int_req`=1 with `int_id`=3 four edges after the rise; ack -> PEND=0, ISR=6'h08, `int_req`=0.
- **Priority:** IER=6'h3F; raise lines 5 and 1 in the same cycle -> `int_id`=1. Ack, then `eoi` -> next request has `int_id`=5.
- **Nesting:** in service on line 4 (ISR=6'h10); event on line 0 -> request with `int_id`=0, ISR=6'h11 after ack. An event on line 5 meanwhile stays pending and is not requested. Two `eoi` pulses clear ISR bit 0 then bit 4, then line 5 is requested.
- **Masking:** IER=6'h01; event on line 2 -> PEND=6'h04, no `int_req`. Write IER=6'h05 -> request `int_id`=2.
- **Withdraw and same-cycle set:** in REQ with `int_id`=2, W1C PEND=6'h04 -> `int_req` drops, state IDLE. Separately, apply a W1C on a bit in the same cycle as a new event on it -> the bit stays 1.
- **Reset mid-operation:** assert `reset` while in REQ with ISR≠0 -> next cycle all registers read 0 and `int_req`=0. A held-high `irq_in` after reset generates one new event.
